// File: rtl/rtc_clock_core_if.sv
// +----------------------------------------------------------------------------+
// | rtc_clock_core_if : register-write and display bundle of the RTC core       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface rtc_clock_core_if;
    logic       i_mode24;
    logic       i_wr;
    logic [2:0] i_sel;
    logic [7:0] i_in;
    logic [7:0] o_hh;
    logic [7:0] o_mm;
    logic [7:0] o_ss;
    logic       o_pm;
    logic       o_tick;
    logic       o_alarm;

    modport master (
        output i_mode24, i_wr, i_sel, i_in,
        input  o_hh, o_mm, o_ss, o_pm, o_tick, o_alarm
    );

    modport slave (
        input  i_mode24, i_wr, i_sel, i_in,
        output o_hh, o_mm, o_ss, o_pm, o_tick, o_alarm
    );
endinterface

`default_nettype wire

// File: rtl/rtc_clock_core.sv
// +----------------------------------------------------------------------------+
// | rtc_clock_core : 1 Hz prescaler, BCD hh:mm:ss, 12h/24h display, one alarm   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module rtc_clock_core #(
    parameter int CLK_HZ   = 12_000_000,
    parameter bit ALARM_EN = 1'b1
) (
    input  wire logic        i_clk,
    input  wire logic        i_reset_n,
    rtc_clock_core_if.slave  bus
);

    localparam int              c_PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_PW-1:0] c_PMAX     = c_PW'(CLK_HZ - 1);
    localparam logic [2:0]      c_SEL_HH   = 3'b000;
    localparam logic [2:0]      c_SEL_MM   = 3'b001;
    localparam logic [2:0]      c_SEL_SS   = 3'b010;
    localparam logic [2:0]      c_SEL_AHH  = 3'b100;
    localparam logic [2:0]      c_SEL_AMM  = 3'b101;
    localparam logic [2:0]      c_SEL_CTRL = 3'b110;

    function automatic logic valid_60(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic valid_24(input logic [7:0] v);
        return (v[3:0] <= 4'd9) &&
               ((v[7:4] < 4'd2) || ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3)));
    endfunction

    function automatic logic [7:0] inc_60(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return (v[7:4] == 4'd5) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_24(input logic [7:0] v);
        if (v == 8'h23)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Hour 00 shows as 12 AM; 13..23 are reduced by twelve in BCD.
    function automatic logic [7:0] to_12h(input logic [7:0] h);
        case (h)
            8'h00:                                     return 8'h12;
            8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
            8'h19:                                     return {4'h0, h[3:0] - 4'd2};
            8'h20:                                     return 8'h08;
            8'h21:                                     return 8'h09;
            8'h22:                                     return 8'h10;
            8'h23:                                     return 8'h11;
            default:                                   return h;
        endcase
    endfunction

    logic [c_PW-1:0] r_presc;
    logic [7:0]      r_hh;
    logic [7:0]      r_mm;
    logic [7:0]      r_ss;
    logic [7:0]      r_disp_hh;
    logic [7:0]      r_disp_mm;
    logic [7:0]      r_disp_ss;
    logic            r_disp_pm;
    logic [7:0]      w_hh_nxt;
    logic [7:0]      w_mm_nxt;
    logic [7:0]      w_ss_nxt;
    logic            w_tick;
    logic            w_wr_hh;
    logic            w_wr_mm;
    logic            w_wr_ss;
    logic            w_wr_time;

    assign w_tick    = (r_presc == c_PMAX);
    assign w_wr_hh   = bus.i_wr && (bus.i_sel == c_SEL_HH) && valid_24(bus.i_in);
    assign w_wr_mm   = bus.i_wr && (bus.i_sel == c_SEL_MM) && valid_60(bus.i_in);
    assign w_wr_ss   = bus.i_wr && (bus.i_sel == c_SEL_SS) && valid_60(bus.i_in);
    assign w_wr_time = w_wr_hh || w_wr_mm || w_wr_ss;

    // A valid time write on a tick cycle swallows that second entirely.
    always_comb begin
        w_hh_nxt = r_hh;
        w_mm_nxt = r_mm;
        w_ss_nxt = r_ss;
        if (w_tick && !w_wr_time) begin
            w_ss_nxt = inc_60(r_ss);
            if (r_ss == 8'h59) begin
                w_mm_nxt = inc_60(r_mm);
                if (r_mm == 8'h59)
                    w_hh_nxt = inc_24(r_hh);
            end
        end
        if (w_wr_hh) w_hh_nxt = bus.i_in;
        if (w_wr_mm) w_mm_nxt = bus.i_in;
        if (w_wr_ss) w_ss_nxt = bus.i_in;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_presc <= '0;
            r_hh    <= 8'h00;
            r_mm    <= 8'h00;
            r_ss    <= 8'h00;
        end else begin
            r_presc <= (w_tick || w_wr_ss) ? '0 : r_presc + c_PW'(1);
            r_hh    <= w_hh_nxt;
            r_mm    <= w_mm_nxt;
            r_ss    <= w_ss_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_disp_hh <= 8'h00;
            r_disp_mm <= 8'h00;
            r_disp_ss <= 8'h00;
            r_disp_pm <= 1'b0;
        end else begin
            r_disp_hh <= bus.i_mode24 ? r_hh : to_12h(r_hh);
            r_disp_mm <= r_mm;
            r_disp_ss <= r_ss;
            r_disp_pm <= !bus.i_mode24 && (r_hh >= 8'h12);
        end
    end

    assign bus.o_hh   = r_disp_hh;
    assign bus.o_mm   = r_disp_mm;
    assign bus.o_ss   = r_disp_ss;
    assign bus.o_pm   = r_disp_pm;
    assign bus.o_tick = w_tick;

    generate
        if (ALARM_EN) begin : g_alarm
            logic [7:0] r_alm_hh;
            logic [7:0] r_alm_mm;
            logic       r_alm_en;
            logic       r_alarm;
            logic       w_ctrl_wr;
            logic       w_ack;
            logic       w_set;

            assign w_ctrl_wr = bus.i_wr && (bus.i_sel == c_SEL_CTRL);
            assign w_ack     = w_ctrl_wr && (bus.i_in[1] || !bus.i_in[0]);
            assign w_set     = w_tick && !w_wr_time && r_alm_en &&
                               (w_ss_nxt == 8'h00) &&
                               (w_hh_nxt == r_alm_hh) && (w_mm_nxt == r_alm_mm);

            always_ff @(posedge i_clk) begin
                if (!i_reset_n) begin
                    r_alm_hh <= 8'h00;
                    r_alm_mm <= 8'h00;
                    r_alm_en <= 1'b0;
                    r_alarm  <= 1'b0;
                end else begin
                    if (bus.i_wr && (bus.i_sel == c_SEL_AHH) && valid_24(bus.i_in))
                        r_alm_hh <= bus.i_in;
                    if (bus.i_wr && (bus.i_sel == c_SEL_AMM) && valid_60(bus.i_in))
                        r_alm_mm <= bus.i_in;
                    if (w_ctrl_wr)
                        r_alm_en <= bus.i_in[0];
                    if (w_ack)
                        r_alarm <= 1'b0;
                    else if (w_set)
                        r_alarm <= 1'b1;
                end
            end

            assign bus.o_alarm = r_alarm;
        end else begin : g_no_alarm
            assign bus.o_alarm = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rtc_clock_core.sv
// +----------------------------------------------------------------------------+
// | tb_rtc_clock_core : directed self-checking bench for rtc_clock_core         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rtc_clock_core;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rtc_clock_core_if bus ();

    rtc_clock_core #(
        .CLK_HZ   (4),
        .ALARM_EN (1'b1)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] s, input logic [7:0] d);
        bus.i_wr  = 1'b1;
        bus.i_sel = s;
        bus.i_in  = d;
        @(posedge clk);
        #1;
        bus.i_wr  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.i_mode24 = 1'b0;
        step(2);
        total++; if (bus.o_hh !== 8'h00)  begin bad++; $display("FAIL rst_hh got=%h exp=00", bus.o_hh); end
        total++; if (bus.o_ss !== 8'h00)  begin bad++; $display("FAIL rst_ss got=%h exp=00", bus.o_ss); end
        total++; if (bus.o_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b exp=0", bus.o_tick); end
        total++; if (bus.o_alarm !== 1'b0) begin bad++; $display("FAIL rst_alarm got=%b exp=0", bus.o_alarm); end
        rst_n = 1'b1;
        step(1);
        total++; if (bus.o_hh !== 8'h12)  begin bad++; $display("FAIL rel_hh got=%h exp=12", bus.o_hh); end
        total++; if (bus.o_mm !== 8'h00)  begin bad++; $display("FAIL rel_mm got=%h exp=00", bus.o_mm); end
        total++; if (bus.o_pm !== 1'b0)   begin bad++; $display("FAIL rel_pm got=%b exp=0", bus.o_pm); end
        for (int n = 2; n <= 9; n++) begin
            logic exp_t;
            step(1);
            exp_t = ((n % 4) == 3);
            total++; if (bus.o_tick !== exp_t) begin bad++; $display("FAIL tick_period edge=%0d got=%b exp=%b", n, bus.o_tick, exp_t); end
        end
        total++; if (bus.o_ss !== 8'h02) begin bad++; $display("FAIL two_ticks_ss got=%h exp=02", bus.o_ss); end
    endtask

    task automatic test_rollover;
        bus.i_mode24 = 1'b0;
        wr(3'b010, 8'h00);
        wr(3'b000, 8'h23);
        wr(3'b001, 8'h59);
        wr(3'b010, 8'h58);
        step(5);
        total++; if (bus.o_hh !== 8'h11) begin bad++; $display("FAIL roll_pre_hh got=%h exp=11", bus.o_hh); end
        total++; if (bus.o_pm !== 1'b1)  begin bad++; $display("FAIL roll_pre_pm got=%b exp=1", bus.o_pm); end
        total++; if (bus.o_ss !== 8'h59) begin bad++; $display("FAIL roll_pre_ss got=%h exp=59", bus.o_ss); end
        step(4);
        total++; if (bus.o_hh !== 8'h12) begin bad++; $display("FAIL roll_hh12 got=%h exp=12", bus.o_hh); end
        total++; if (bus.o_pm !== 1'b0)  begin bad++; $display("FAIL roll_pm got=%b exp=0", bus.o_pm); end
        total++; if (bus.o_mm !== 8'h00) begin bad++; $display("FAIL roll_mm got=%h exp=00", bus.o_mm); end
        total++; if (bus.o_ss !== 8'h00) begin bad++; $display("FAIL roll_ss got=%h exp=00", bus.o_ss); end
        bus.i_mode24 = 1'b1;
        step(1);
        total++; if (bus.o_hh !== 8'h00) begin bad++; $display("FAIL roll_hh24 got=%h exp=00", bus.o_hh); end
    endtask

    task automatic test_12h;
        logic [7:0] hv [6];
        logic [7:0] h12[6];
        logic       pmv[6];
        hv  = '{8'h13, 8'h00, 8'h12, 8'h22, 8'h11, 8'h09};
        h12 = '{8'h01, 8'h12, 8'h12, 8'h10, 8'h11, 8'h09};
        pmv = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        for (int k = 0; k < 6; k++) begin
            wr(3'b010, 8'h00);
            wr(3'b000, hv[k]);
            bus.i_mode24 = 1'b0;
            step(1);
            total++; if (bus.o_hh !== h12[k]) begin bad++; $display("FAIL h12_hh in=%h got=%h exp=%h", hv[k], bus.o_hh, h12[k]); end
            total++; if (bus.o_pm !== pmv[k]) begin bad++; $display("FAIL h12_pm in=%h got=%b exp=%b", hv[k], bus.o_pm, pmv[k]); end
            bus.i_mode24 = 1'b1;
            step(1);
            total++; if (bus.o_hh !== hv[k]) begin bad++; $display("FAIL h24_hh in=%h got=%h exp=%h", hv[k], bus.o_hh, hv[k]); end
            total++; if (bus.o_pm !== 1'b0)  begin bad++; $display("FAIL h24_pm in=%h got=%b exp=0", hv[k], bus.o_pm); end
        end
    endtask

    task automatic test_invalid;
        bus.i_mode24 = 1'b1;
        wr(3'b010, 8'h00);
        wr(3'b000, 8'h05);
        wr(3'b001, 8'h20);
        wr(3'b001, 8'h5A);
        wr(3'b000, 8'h24);
        step(1);
        total++; if (bus.o_hh !== 8'h05) begin bad++; $display("FAIL inv_hh got=%h exp=05", bus.o_hh); end
        total++; if (bus.o_mm !== 8'h20) begin bad++; $display("FAIL inv_mm got=%h exp=20", bus.o_mm); end
        wr(3'b010, 8'h60);
        wr(3'b000, 8'h1A);
        total++; if (bus.o_ss !== 8'h01) begin bad++; $display("FAIL inv_ss got=%h exp=01", bus.o_ss); end
        step(1);
        total++; if (bus.o_hh !== 8'h05) begin bad++; $display("FAIL inv_hh_nib got=%h exp=05", bus.o_hh); end
    endtask

    task automatic test_alarm;
        bus.i_mode24 = 1'b1;
        wr(3'b100, 8'h07);
        wr(3'b101, 8'h30);
        wr(3'b110, 8'h01);
        wr(3'b010, 8'h00);
        wr(3'b000, 8'h07);
        wr(3'b001, 8'h29);
        wr(3'b010, 8'h59);
        step(3);
        total++; if (bus.o_alarm !== 1'b0) begin bad++; $display("FAIL alm_early got=%b exp=0", bus.o_alarm); end
        step(1);
        total++; if (bus.o_alarm !== 1'b1) begin bad++; $display("FAIL alm_set got=%b exp=1", bus.o_alarm); end
        step(1);
        total++; if (bus.o_mm !== 8'h30) begin bad++; $display("FAIL alm_mm got=%h exp=30", bus.o_mm); end
        total++; if (bus.o_ss !== 8'h00) begin bad++; $display("FAIL alm_ss got=%h exp=00", bus.o_ss); end
        wr(3'b101, 8'h45);
        total++; if (bus.o_alarm !== 1'b1) begin bad++; $display("FAIL alm_hold got=%b exp=1", bus.o_alarm); end
        wr(3'b110, 8'h03);
        total++; if (bus.o_alarm !== 1'b0) begin bad++; $display("FAIL alm_ack got=%b exp=0", bus.o_alarm); end
    endtask

    task automatic test_tick_write;
        int n;
        bus.i_mode24 = 1'b1;
        wr(3'b010, 8'h59);
        n = 0;
        while (bus.o_tick !== 1'b1 && n < 8) begin
            step(1);
            n++;
        end
        total++; if (n !== 3) begin bad++; $display("FAIL tw_align got=%0d exp=3", n); end
        wr(3'b010, 8'h10);
        step(1);
        total++; if (bus.o_ss !== 8'h10) begin bad++; $display("FAIL tw_ss got=%h exp=10", bus.o_ss); end
        total++; if (bus.o_mm !== 8'h30) begin bad++; $display("FAIL tw_nocarry got=%h exp=30", bus.o_mm); end
        step(1);
        total++; if (bus.o_tick !== 1'b0) begin bad++; $display("FAIL tw_tick_early got=%b exp=0", bus.o_tick); end
        step(1);
        total++; if (bus.o_tick !== 1'b1) begin bad++; $display("FAIL tw_tick got=%b exp=1", bus.o_tick); end
        step(1);
        total++; if (bus.o_ss !== 8'h10) begin bad++; $display("FAIL tw_ss_hold got=%h exp=10", bus.o_ss); end
        step(1);
        total++; if (bus.o_ss !== 8'h11) begin bad++; $display("FAIL tw_ss_next got=%h exp=11", bus.o_ss); end
    endtask

    task automatic test_reset_mid;
        step(2);
        total++; if (bus.o_tick !== 1'b1) begin bad++; $display("FAIL mid_pre_tick got=%b exp=1", bus.o_tick); end
        rst_n = 1'b0;
        step(1);
        total++; if (bus.o_tick !== 1'b0) begin bad++; $display("FAIL mid_tick got=%b exp=0", bus.o_tick); end
        total++; if (bus.o_hh !== 8'h00)  begin bad++; $display("FAIL mid_hh got=%h exp=00", bus.o_hh); end
        rst_n = 1'b1;
        step(1);
        total++; if (bus.o_ss !== 8'h00)  begin bad++; $display("FAIL mid_rel_ss got=%h exp=00", bus.o_ss); end
        total++; if (bus.o_mm !== 8'h00)  begin bad++; $display("FAIL mid_rel_mm got=%h exp=00", bus.o_mm); end
        step(1);
        total++; if (bus.o_tick !== 1'b0) begin bad++; $display("FAIL mid_rel_tick got=%b exp=0", bus.o_tick); end
        step(1);
        total++; if (bus.o_tick !== 1'b1) begin bad++; $display("FAIL mid_first_tick got=%b exp=1", bus.o_tick); end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        bus.i_mode24 = 1'b0;
        bus.i_wr     = 1'b0;
        bus.i_sel    = 3'b000;
        bus.i_in     = 8'h00;
        test_reset();
        test_rollover();
        test_12h();
        test_invalid();
        test_alarm();
        test_tick_write();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
